// File: rtl/fetch_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_ctrl_pkg
// Description : Shared types and constants for the instruction-fetch front
//               end: fetch FSM state encoding, reset PC and PC increment.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_ctrl_pkg;

  // BOOT    : one idle cycle after reset before the first request
  // REQ     : presenting (or ready to present) a request for fetch_pc
  // WAIT    : one request accepted, waiting for its instruction
  // CANCEL  : one request accepted but made stale; its data is discarded
  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_REQ    = 2'd1,
    ST_WAIT   = 2'd2,
    ST_CANCEL = 2'd3
  } fetch_state_e;

  localparam logic [31:0] C_PC_INIT_VAL = 32'h1C00_0000;
  localparam logic [31:0] C_INST_BYTES  = 32'd4;

  // Sequential successor; wraps modulo 2^32.
  function automatic logic [31:0] seq_pc(input logic [31:0] pc,
                                         input logic [31:0] step);
    return pc + step;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_ctrl_if
// Description : Fetch-to-icache request/response bus.
//               master : fetch side  (drives icache_req, icache_addr)
//               slave  : icache side (drives addr_ok, data_ok, rdata)
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_ctrl_if;
  logic        icache_req;
  logic [31:0] icache_addr;
  logic        icache_addr_ok;
  logic        icache_data_ok;
  logic [31:0] icache_rdata;

  modport master (
    output icache_req,
    output icache_addr,
    input  icache_addr_ok,
    input  icache_data_ok,
    input  icache_rdata
  );

  modport slave (
    input  icache_req,
    input  icache_addr,
    output icache_addr_ok,
    output icache_data_ok,
    output icache_rdata
  );
endinterface
`default_nettype wire

// File: rtl/fetch_ctrl_if_slot.sv
`default_nettype none
// ============================================================================
// Module      : fetch_ctrl_if_slot
// Description : One-entry registered output buffer between fetch and ID.
//   cpu_clk/cpu_rst : clock, synchronous active-high reset
//   wr_en / wr_*    : load a returned instruction with its prediction
//   flush           : redirect; drops the held instruction
//   consume         : ID takes the held instruction this cycle
//   if_*            : registered slot contents
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_ctrl_if_slot (
  input  wire logic        cpu_clk,
  input  wire logic        cpu_rst,
  input  wire logic        wr_en,
  input  wire logic        flush,
  input  wire logic        consume,
  input  wire logic [31:0] wr_pc,
  input  wire logic [31:0] wr_inst,
  input  wire logic        wr_pred_taken,
  input  wire logic [31:0] wr_pred_target,
  output logic             if_valid,
  output logic [31:0]      if_pc,
  output logic [31:0]      if_inst,
  output logic             if_pred_taken,
  output logic [31:0]      if_pred_target
);

  logic        r_valid;
  logic [31:0] r_pc;
  logic [31:0] r_inst;
  logic        r_pred_taken;
  logic [31:0] r_pred_target;

  // Flush dominates a write; the payload is only touched on a write so a
  // stalled or consumed slot keeps its outputs stable.
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      r_valid       <= 1'b0;
      r_pc          <= '0;
      r_inst        <= '0;
      r_pred_taken  <= 1'b0;
      r_pred_target <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (wr_en) begin
      r_valid       <= 1'b1;
      r_pc          <= wr_pc;
      r_inst        <= wr_inst;
      r_pred_taken  <= wr_pred_taken;
      r_pred_target <= wr_pred_target;
    end else if (consume) begin
      r_valid <= 1'b0;
    end
  end

  assign if_valid       = r_valid;
  assign if_pc          = r_pc;
  assign if_inst        = r_inst;
  assign if_pred_taken  = r_pred_taken;
  assign if_pred_target = r_pred_target;

endmodule
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fetch_ctrl
// Description : Instruction-fetch sequencer. Owns the fetch PC, issues one
//               outstanding icache request at a time, picks the next PC
//               (exception > EX redirect > BTB > +INST_BYTES) and cancels
//               responses made stale by a redirect.
//   cpu_clk/cpu_rst     : clock, synchronous active-high reset
//   suspend             : ID stall, slot is not consumed
//   icache (master)     : request/response bus to the icache
//   pred_taken/target   : BTB lookup for the current fetch PC
//   ex_redirect(_pc)    : EX-stage branch/jump correction
//   exc_redirect/exc_pc : exception / ertn flush
//   if_*                : output slot towards ID
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] PC_INIT_VAL = C_PC_INIT_VAL,
  parameter logic [31:0] INST_BYTES  = C_INST_BYTES
) (
  input  wire logic        cpu_clk,
  input  wire logic        cpu_rst,
  input  wire logic        suspend,
  fetch_ctrl_if.master     icache,
  input  wire logic        pred_taken,
  input  wire logic [31:0] pred_target,
  input  wire logic        ex_redirect,
  input  wire logic [31:0] ex_redirect_pc,
  input  wire logic        exc_redirect,
  input  wire logic [31:0] exc_pc,
  output logic             if_valid,
  output logic [31:0]      if_pc,
  output logic [31:0]      if_inst,
  output logic             if_pred_taken,
  output logic [31:0]      if_pred_target
);

  fetch_state_e r_state;
  fetch_state_e w_state_next;
  logic [31:0]  r_fetch_pc;
  logic [31:0]  w_fetch_pc_next;

  logic         w_redir;
  logic [31:0]  w_redir_pc;
  logic         w_consume;
  logic         w_free;
  logic         w_req;
  logic         w_slot_wr;

  assign w_redir    = exc_redirect | ex_redirect;
  assign w_redir_pc = exc_redirect ? exc_pc : ex_redirect_pc;
  assign w_consume  = if_valid & ~suspend;
  // Requesting only when the slot will be empty guarantees the returning
  // instruction always has a place to land.
  assign w_free     = ~if_valid | w_consume;

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      r_state    <= ST_BOOT;
      r_fetch_pc <= PC_INIT_VAL;
    end else begin
      r_state    <= w_state_next;
      r_fetch_pc <= w_fetch_pc_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_fetch_pc_next = r_fetch_pc;
    w_req           = 1'b0;
    w_slot_wr       = 1'b0;

    case (r_state)
      ST_BOOT: begin
        if (w_redir) w_fetch_pc_next = w_redir_pc;
        w_state_next = ST_REQ;
      end

      ST_REQ: begin
        w_req = w_free;
        if (w_redir) begin
          w_fetch_pc_next = w_redir_pc;
          // A request accepted alongside a redirect fetches a stale PC.
          if (icache.icache_addr_ok && w_req) w_state_next = ST_CANCEL;
        end else if (icache.icache_addr_ok && w_req) begin
          w_state_next = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (w_redir) begin
          w_fetch_pc_next = w_redir_pc;
          w_state_next    = icache.icache_data_ok ? ST_REQ : ST_CANCEL;
        end else if (icache.icache_data_ok) begin
          w_slot_wr       = 1'b1;
          w_fetch_pc_next = pred_taken ? pred_target
                                       : seq_pc(r_fetch_pc, INST_BYTES);
          w_state_next    = ST_REQ;
        end
      end

      ST_CANCEL: begin
        if (w_redir) w_fetch_pc_next = w_redir_pc;
        if (icache.icache_data_ok) w_state_next = ST_REQ;
      end

      default: w_state_next = ST_BOOT;
    endcase
  end

  assign icache.icache_req  = w_req;
  assign icache.icache_addr = r_fetch_pc;

  fetch_ctrl_if_slot u_slot (
    .cpu_clk        (cpu_clk),
    .cpu_rst        (cpu_rst),
    .wr_en          (w_slot_wr),
    .flush          (w_redir),
    .consume        (w_consume),
    .wr_pc          (r_fetch_pc),
    .wr_inst        (icache.icache_rdata),
    .wr_pred_taken  (pred_taken),
    .wr_pred_target (pred_target),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_inst        (if_inst),
    .if_pred_taken  (if_pred_taken),
    .if_pred_target (if_pred_target)
  );

endmodule
`default_nettype wire
